if_id_stage: RTL and testbench
==============================

IF_ID_STAGE -- requirements
Module: if_id_stage

Interface
REQ-001 SHALL have parameter ADDR_W, default 10: instruction-memory word-address width.
REQ-002 SHALL have port Clk, input, 1: single clock; all state updates on posedge.
REQ-003 SHALL have port Reset, input, 1: reset, synchronous and active-high.
REQ-004 SHALL have port PC, input, 32: current fetch byte address from the program counter register.
REQ-005 SHALL have port ID_stall, input, 1: decode stall; hold the IF/ID register.
REQ-006 SHALL have port IF_flush, input, 1: taken branch/jump in ID; kill the in-flight fetch.
REQ-007 SHALL have port imem_addr, output, ADDR_W: word address to synchronous BRAM, equal to PC[ADDR_W+1:2], combinational.
REQ-008 SHALL have port imem_rdata, input, 32: BRAM read data, one cycle after imem_addr.
REQ-009 SHALL have ports IFID_instr (32), IFID_PC_plus4 (32) and IFID_valid (1), all outputs: registered IF/ID payload.
REQ-010 SHALL have ports fetch_count (32) and stall_count (32), both outputs: performance counters (see Configuration).

Function
REQ-011 SHALL track the in-flight fetch in registers f_pc and f_valid; when ID_stall=0 these load PC and 1 on each edge; when ID_stall=1 they hold.
REQ-012 SHALL use FSM states RUN and HELD. RUN->HELD on an edge with ID_stall=1 and skid empty; HELD->RUN on the first edge with ID_stall=0.
REQ-013 SHALL capture imem_rdata into a skid register on the RUN->HELD edge, because BRAM returns data for the stalled PC afterwards.
REQ-014 SHALL select the instruction source as the skid register in HELD and imem_rdata in RUN.
REQ-015 SHALL, on an edge with ID_stall=0 and IF_flush=0, load IFID_instr with the selected instruction, IFID_PC_plus4 with f_pc+4, and IFID_valid with f_valid.
REQ-016 SHALL, on an edge with IF_flush=1 and ID_stall=0, load IFID_instr with NOP (32'h0), load IFID_valid with 0, load IFID_PC_plus4 with f_pc+4, clear the skid register, and go to RUN.
REQ-017 SHALL hold all IF/ID outputs on an edge with ID_stall=1.
REQ-018 SHALL give ID_stall priority when ID_stall and IF_flush are both 1: IF_flush is ignored and upstream re-asserts it.
REQ-019 SHALL compute f_pc+4 modulo 2^32, so 32'hFFFFFFFC yields 32'h0.
REQ-020 SHALL have latency PC to IFID outputs of exactly 2 edges when unstalled, with throughput 1 instruction per cycle.
REQ-021 SHALL, for a stall of any length, keep the instruction delivered after the stall equal to the BRAM word at f_pc, never the word at PC.

Reset
REQ-022 SHALL, on an edge with Reset=1, set IFID_instr=0, IFID_PC_plus4=0, IFID_valid=0, f_pc=0, f_valid=0, skid=0, state=RUN, and both counters=0.
REQ-023 SHALL give Reset priority over ID_stall and IF_flush, including mid-stall with HELD discarded.
REQ-024 SHALL drive IFID_valid=0 on the first edge after Reset deasserts, since f_valid=0.

Configuration
REQ-025 SHALL, with macro IF_ID_PERF_COUNT_EN defined, increment fetch_count on each edge loading IFID_valid=1 and increment stall_count on each edge with ID_stall=1; both wrap at 2^32.
REQ-026 SHALL, with IF_ID_PERF_COUNT_EN undefined, keep the fetch_count and stall_count ports present, tie them to 0, and infer no counter flops.

Structure
REQ-027 SHALL place the NOP constant 32'h0000_0000 and the RUN/HELD state encoding in shared package cpu_pkg.
REQ-028 SHALL implement the skid register, its valid flag and the FSM as sub-module if_skid_buffer; if_id_stage instantiates it once.

Verification
REQ-029 SHALL verify streaming: Reset 2 cycles, then PC=0,4,8 on successive cycles with mem[0..2]=A,B,C -> IFID_instr A,B,C on edges 2,3,4 with IFID_PC_plus4=4,8,12 and valid=1.
REQ-030 SHALL verify a 3-cycle stall: ID_stall=1 while f_pc=8 and PC=12 -> IFID held, skid=mem[2]; after release IFID_instr=mem[2] then mem[3], with no duplicate and no loss; stall_count=3 when the macro is defined.
REQ-031 SHALL verify flush: IF_flush=1 for one cycle with f_pc=16 -> next IFID_valid=0 and IFID_instr=0; the following fetch is valid.
REQ-032 SHALL verify simultaneous ID_stall=1 and IF_flush=1 -> outputs held and skid unchanged.
REQ-033 SHALL verify Reset asserted in HELD -> all outputs 0, state RUN, and first post-reset IFID_valid=0.
REQ-034 SHALL verify wrap: f_pc=32'hFFFFFFFC -> IFID_PC_plus4=0.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: fetch FSM state encoding, the NOP word and a
// small PC helper used by the IF/ID stage.
package cpu_pkg;

   typedef enum logic {
      RUN  = 1'b0,
      HELD = 1'b1
   } fetch_state_t;

   localparam logic [31:0] NOP = 32'h0000_0000;

   // Next sequential byte address; natural 32-bit wrap at the top of memory.
   function automatic logic [31:0] pc_plus4(input logic [31:0] pc);
      return pc + 32'd4;
   endfunction

endpackage

// File: rtl/if_skid_buffer.sv
// Fetch skid buffer: while decode is stalled the BRAM keeps reading the
// newer PC, so the word for the stalled fetch is parked here and replayed
// when the stall releases.
module if_skid_buffer
   import cpu_pkg::*;
(
   input  logic        Clk,
   input  logic        Reset,
   input  logic        ID_stall,
   input  logic        IF_flush,
   input  logic [31:0] imem_rdata,
   output logic [31:0] sel_instr
);

   fetch_state_t state;
   fetch_state_t next_state;
   logic [31:0]  skid_data;
   logic         skid_valid;
   logic         capture;

   // State register for the RUN/HELD fetch FSM.
   always_ff @(posedge Clk) begin
      if (Reset) begin
         state <= RUN;
      end else begin
         state <= next_state;
      end
   end

   // Next state: enter HELD on the first stalled edge, leave on release.
   always_comb begin
      next_state = state;
      capture    = 1'b0;
      case (state)
         RUN: begin
            if (ID_stall && !skid_valid) begin
               next_state = HELD;
               capture    = 1'b1;
            end
         end
         HELD: begin
            if (!ID_stall) begin
               next_state = RUN;
            end
         end
         default: next_state = RUN;
      endcase
   end

   // Skid storage: grab the stalled fetch word, drop it on flush or release.
   always_ff @(posedge Clk) begin
      if (Reset) begin
         skid_data  <= NOP;
         skid_valid <= 1'b0;
      end else if (!ID_stall && IF_flush) begin
         skid_data  <= NOP;
         skid_valid <= 1'b0;
      end else if (capture) begin
         skid_data  <= imem_rdata;
         skid_valid <= 1'b1;
      end else if (state == HELD && !ID_stall) begin
         skid_valid <= 1'b0;
      end
   end

   assign sel_instr = (state == HELD) ? skid_data : imem_rdata;

endmodule

// File: rtl/if_id_stage.sv
// IF/ID pipeline stage for a synchronous-BRAM instruction memory.
// Optional performance counters are built when IF_ID_PERF_COUNT_EN is
// defined; otherwise fetch_count/stall_count read as zero.
module if_id_stage
   import cpu_pkg::*;
#(
   parameter int ADDR_W = 10
)
(
   input  logic              Clk,
   input  logic              Reset,
   input  logic [31:0]       PC,
   input  logic              ID_stall,
   input  logic              IF_flush,
   output logic [ADDR_W-1:0] imem_addr,
   input  logic [31:0]       imem_rdata,
   output logic [31:0]       IFID_instr,
   output logic [31:0]       IFID_PC_plus4,
   output logic              IFID_valid,
   output logic [31:0]       fetch_count,
   output logic [31:0]       stall_count
);

   logic [31:0] f_pc;
   logic        f_valid;
   logic [31:0] sel_instr;
   logic        unused_pc_bits;

   assign imem_addr      = PC[ADDR_W+1:2];
   assign unused_pc_bits = ^{PC[31:ADDR_W+2], PC[1:0]};

   if_skid_buffer u_skid_buffer (
      .Clk        (Clk),
      .Reset      (Reset),
      .ID_stall   (ID_stall),
      .IF_flush   (IF_flush),
      .imem_rdata (imem_rdata),
      .sel_instr  (sel_instr)
   );

   // In-flight fetch tracker: mirrors the PC the BRAM is currently reading.
   always_ff @(posedge Clk) begin
      if (Reset) begin
         f_pc    <= 32'd0;
         f_valid <= 1'b0;
      end else if (!ID_stall) begin
         f_pc    <= PC;
         f_valid <= 1'b1;
      end
   end

   // IF/ID register: stall holds, flush injects a NOP bubble.
   always_ff @(posedge Clk) begin
      if (Reset) begin
         IFID_instr    <= NOP;
         IFID_PC_plus4 <= 32'd0;
         IFID_valid    <= 1'b0;
      end else if (!ID_stall) begin
         IFID_PC_plus4 <= pc_plus4(f_pc);
         if (IF_flush) begin
            IFID_instr <= NOP;
            IFID_valid <= 1'b0;
         end else begin
            IFID_instr <= sel_instr;
            IFID_valid <= f_valid;
         end
      end
   end

`ifdef IF_ID_PERF_COUNT_EN
   logic [31:0] fetch_cnt;
   logic [31:0] stall_cnt;

   // Performance counters: delivered valid instructions and stalled cycles.
   always_ff @(posedge Clk) begin
      if (Reset) begin
         fetch_cnt <= 32'd0;
         stall_cnt <= 32'd0;
      end else begin
         if (ID_stall) begin
            stall_cnt <= stall_cnt + 32'd1;
         end
         if (!ID_stall && !IF_flush && f_valid) begin
            fetch_cnt <= fetch_cnt + 32'd1;
         end
      end
   end

   assign fetch_count = fetch_cnt;
   assign stall_count = stall_cnt;
`else
   assign fetch_count = 32'd0;
   assign stall_count = 32'd0;
`endif

endmodule

// File: tb/tb_if_id_stage.sv
// Directed bench for if_id_stage with a behavioural synchronous BRAM.
module tb_if_id_stage;
   import cpu_pkg::*;

   localparam int ADDR_W = 10;
`ifdef IF_ID_PERF_COUNT_EN
   localparam bit PerfEn = 1'b1;
`else
   localparam bit PerfEn = 1'b0;
`endif

   logic              Clk;
   logic              Reset;
   logic [31:0]       PC;
   logic              ID_stall;
   logic              IF_flush;
   logic [ADDR_W-1:0] imem_addr;
   logic [31:0]       imem_rdata;
   logic [31:0]       IFID_instr;
   logic [31:0]       IFID_PC_plus4;
   logic              IFID_valid;
   logic [31:0]       fetch_count;
   logic [31:0]       stall_count;

   logic [31:0] mem [0:(1<<ADDR_W)-1];
   int assertCount;
   int failCount;

   if_id_stage #(.ADDR_W(ADDR_W)) dut (
      .Clk           (Clk),
      .Reset         (Reset),
      .PC            (PC),
      .ID_stall      (ID_stall),
      .IF_flush      (IF_flush),
      .imem_addr     (imem_addr),
      .imem_rdata    (imem_rdata),
      .IFID_instr    (IFID_instr),
      .IFID_PC_plus4 (IFID_PC_plus4),
      .IFID_valid    (IFID_valid),
      .fetch_count   (fetch_count),
      .stall_count   (stall_count)
   );

   // Free-running clock.
   initial begin
      Clk = 1'b0;
      forever #5 Clk = ~Clk;
   end

   // Synchronous BRAM: data for an address appears one edge later.
   always @(posedge Clk) begin
      imem_rdata <= mem[imem_addr];
   end

   // Drive one set of inputs, take one edge, return 1 time unit after it.
   task automatic applyStimulus(input logic rst, input logic [31:0] pc,
                                input logic stall, input logic flush);
      Reset    = rst;
      PC       = pc;
      ID_stall = stall;
      IF_flush = flush;
      @(posedge Clk);
      #1;
   endtask

   // Compare one observed value against its hand-computed expectation.
   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      assertCount++;
      assert (observed === expected)
      else begin
         failCount++;
         $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
      end
   endtask

   task automatic checkIfid(input string tag, input logic [31:0] instr,
                            input logic [31:0] pc4, input logic valid);
      checkOutput({tag, ".instr"}, IFID_instr, instr);
      checkOutput({tag, ".pc4"}, IFID_PC_plus4, pc4);
      checkOutput({tag, ".valid"}, {31'b0, IFID_valid}, {31'b0, valid});
   endtask

   // Directed sequence: stream, stall, flush, stall+flush, reset in HELD, wrap.
   initial begin
      assertCount = 0;
      failCount   = 0;
      imem_rdata  = 32'd0;
      for (int i = 0; i < (1 << ADDR_W); i++) begin
         mem[i] = 32'hC0DE_0000 + i;
      end

      applyStimulus(1'b1, 32'd0, 1'b0, 1'b0);
      applyStimulus(1'b1, 32'd0, 1'b0, 1'b0);
      checkIfid("reset", 32'h0, 32'h0, 1'b0);
      checkOutput("reset.fetch_count", fetch_count, 32'd0);
      checkOutput("reset.stall_count", stall_count, 32'd0);
      checkOutput("reset.state", 32'(dut.u_skid_buffer.state), 32'(RUN));

      // Streaming PC=0,4,8 (then 12): A,B,C on edges 2,3,4.
      applyStimulus(1'b0, 32'd0, 1'b0, 1'b0);
      checkOutput("post_reset.valid", {31'b0, IFID_valid}, 32'd0);
      checkOutput("addr.pc0", {22'b0, imem_addr}, 32'd0);
      applyStimulus(1'b0, 32'd4, 1'b0, 1'b0);
      checkIfid("stream_a", 32'hC0DE_0000, 32'd4, 1'b1);
      applyStimulus(1'b0, 32'd8, 1'b0, 1'b0);
      checkIfid("stream_b", 32'hC0DE_0001, 32'd8, 1'b1);
      applyStimulus(1'b0, 32'd12, 1'b0, 1'b0);
      checkIfid("stream_c", 32'hC0DE_0002, 32'd12, 1'b1);

      // Redirect back to 8 so the stall lands with f_pc=8 and PC=12.
      applyStimulus(1'b0, 32'd8, 1'b0, 1'b0);
      checkIfid("stream_d", 32'hC0DE_0003, 32'd16, 1'b1);
      applyStimulus(1'b0, 32'd12, 1'b1, 1'b0);
      checkIfid("stall1", 32'hC0DE_0003, 32'd16, 1'b1);
      checkOutput("stall1.skid", dut.u_skid_buffer.skid_data, 32'hC0DE_0002);
      checkOutput("stall1.state", 32'(dut.u_skid_buffer.state), 32'(HELD));
      applyStimulus(1'b0, 32'd12, 1'b1, 1'b0);
      applyStimulus(1'b0, 32'd12, 1'b1, 1'b0);
      checkIfid("stall3", 32'hC0DE_0003, 32'd16, 1'b1);
      checkOutput("stall3.skid", dut.u_skid_buffer.skid_data, 32'hC0DE_0002);
      checkOutput("stall3.stall_count", stall_count, PerfEn ? 32'd3 : 32'd0);
      applyStimulus(1'b0, 32'd12, 1'b0, 1'b0);
      checkIfid("release", 32'hC0DE_0002, 32'd12, 1'b1);
      checkOutput("release.state", 32'(dut.u_skid_buffer.state), 32'(RUN));
      applyStimulus(1'b0, 32'd16, 1'b0, 1'b0);
      checkIfid("after_release", 32'hC0DE_0003, 32'd16, 1'b1);
      checkOutput("fetch_count", fetch_count, PerfEn ? 32'd6 : 32'd0);

      // Flush with f_pc=16: bubble, then the next fetch is valid.
      applyStimulus(1'b0, 32'd20, 1'b0, 1'b1);
      checkIfid("flush", 32'h0, 32'd20, 1'b0);
      applyStimulus(1'b0, 32'd24, 1'b0, 1'b0);
      checkIfid("post_flush", 32'hC0DE_0005, 32'd24, 1'b1);

      // Stall, then stall together with flush: flush is ignored.
      applyStimulus(1'b0, 32'd28, 1'b1, 1'b0);
      checkOutput("sf.skid0", dut.u_skid_buffer.skid_data, 32'hC0DE_0006);
      applyStimulus(1'b0, 32'd28, 1'b1, 1'b1);
      checkIfid("stall_flush", 32'hC0DE_0005, 32'd24, 1'b1);
      checkOutput("stall_flush.skid", dut.u_skid_buffer.skid_data, 32'hC0DE_0006);
      checkOutput("stall_flush.state", 32'(dut.u_skid_buffer.state), 32'(HELD));
      applyStimulus(1'b0, 32'd28, 1'b0, 1'b0);
      checkIfid("sf_release", 32'hC0DE_0006, 32'd28, 1'b1);

      // Reset while HELD.
      applyStimulus(1'b0, 32'd32, 1'b1, 1'b0);
      checkOutput("pre_reset.state", 32'(dut.u_skid_buffer.state), 32'(HELD));
      applyStimulus(1'b1, 32'd32, 1'b1, 1'b1);
      checkIfid("reset_held", 32'h0, 32'h0, 1'b0);
      checkOutput("reset_held.state", 32'(dut.u_skid_buffer.state), 32'(RUN));
      checkOutput("reset_held.skid", dut.u_skid_buffer.skid_data, 32'h0);
      checkOutput("reset_held.fetch_count", fetch_count, 32'd0);
      checkOutput("reset_held.stall_count", stall_count, 32'd0);
      applyStimulus(1'b0, 32'd0, 1'b0, 1'b0);
      checkOutput("reset_held.first_valid", {31'b0, IFID_valid}, 32'd0);

      // PC+4 wrap at the top of the address space.
      applyStimulus(1'b0, 32'hFFFF_FFFC, 1'b0, 1'b0);
      checkOutput("addr.top", {22'b0, imem_addr}, 32'h0000_03FF);
      checkIfid("pre_wrap", 32'hC0DE_0000, 32'd4, 1'b1);
      applyStimulus(1'b0, 32'd0, 1'b0, 1'b0);
      checkIfid("wrap", 32'hC0DE_03FF, 32'h0, 1'b1);

      $display("End of test - %0d assertions evaluated, %0d failures",
               assertCount, failCount);
      $finish;
   end

endmodule
